note_scheduler: RTL and testbench
=================================

# note_scheduler

Round-robin scheduler that serves next-song-note requests from the on-screen walls of the note game. It owns the song position pointer and the read port of the song note memory (SONG_LEN × 16-bit frequencies). It hands each requesting wall exactly one frequency with a one-hot acknowledge, and flags the final note of the song. It sits between the wall-positioning logic (requesters) and the note memory, in the pixel clock domain.

## Interface
Parameters:
- WALL_COUNT, 3, number of requesters (walls); ≥2.
- SONG_LEN, 32, number of notes in the song memory.
- ADDR_WIDTH, 5, note memory address width; 2^ADDR_WIDTH ≥ SONG_LEN.
- FREQ_WIDTH, 16, note frequency width.

Ports:
- pixel_clk_in  input  1  sole clock.
- rst_in  input  1  reset; asynchronous, active-high.
- start_in  input  1  one-cycle pulse; starts the song from IDLE or restarts it from DONE.
- req_in  input  WALL_COUNT  per-wall level request; held high until the matching ack_out.
- ack_out  output  WALL_COUNT  one-hot, one-cycle grant that accompanies freq_out.
- freq_out  output  FREQ_WIDTH  note frequency for the acked wall; registered and held until the next ack.
- valid_out  output  1  high in the ack cycle.
- mem_addr_out  output  ADDR_WIDTH  note memory read address.
- mem_rd_out  output  1  note memory read enable.
- mem_data_in  input  FREQ_WIDTH  memory read data; valid 1 cycle after mem_rd_out is high.
- song_idx_out  output  ADDR_WIDTH  index of the next note to issue.
- final_note_out  output  1  one-cycle pulse, coincident with the ack of note SONG_LEN-1.
- state_out  output  3  FSM state, for debug and game FSM.

## Operation
- FSM encoding: IDLE=0, ARB=1, FETCH=2, CAPTURE=3, ISSUE=4, DONE=5.
- IDLE: all requests ignored. On start_in, go to ARB with song_idx=0.
- ARB:
  - Form mask = req_in with the bit of the previous ack cleared, if the previous state was ISSUE.
  - If mask=0, stay in ARB.
  - Otherwise the winner is the first set bit at or after (last_grant+1) mod WALL_COUNT.
  - Register grant_idx=winner, mem_addr_out=song_idx, mem_rd_out=1. Go to FETCH.
- FETCH: mem_rd_out=1 for this cycle only. Go to CAPTURE.
- CAPTURE: mem_data_in is valid.
  - Register freq_out=mem_data_in, ack_out=onehot(grant_idx), valid_out=1.
  - last_grant=grant_idx.
  - final_note_out=1 if song_idx==SONG_LEN-1.
  - Go to ISSUE.
- ISSUE: ack/valid/final pulses are visible this cycle.
  - At the end of the cycle they clear and song_idx advances.
  - If song_idx was SONG_LEN-1: go to DONE (see Configuration). Otherwise song_idx+1, go to ARB.
- DONE: requests ignored, no acks. On start_in: song_idx=0, last_grant=WALL_COUNT-1, go to ARB.
- start_in outside IDLE/DONE is ignored.
- req_in dropping before ack is legal. The winner is still acked; requesters must tolerate this.
- Reset (asynchronous, any state, including mid-FETCH):
  - state=IDLE, song_idx=0, last_grant=WALL_COUNT-1 (wall 0 has first priority).
  - ack_out=0, valid_out=0, final_note_out=0, freq_out=0, mem_rd_out=0, mem_addr_out=0.
  - state_out=0, song_idx_out=0.

## Timing
- Request to ack: request sampled in ARB cycle N → mem_rd_out high in N+1 → data captured at end of N+2 → ack_out/valid_out high in N+3.
- Back-to-back issue: one note per 4 cycles (ARB, FETCH, CAPTURE, ISSUE).
- song_idx_out updates in the cycle after ISSUE.
- All outputs are registered; there are no combinational input→output paths.
- Simultaneous requests resolve strictly round-robin. No requester waits more than WALL_COUNT-1 grants.
- Arithmetic: song_idx compares against SONG_LEN-1 and never exceeds it. Round-robin wrap is mod WALL_COUNT.

## Configuration
- SONG_LOOP_EN defined:
  - After issuing note SONG_LEN-1 (final_note_out still pulses), song_idx wraps to 0 and the FSM returns to ARB.
  - DONE is unreachable except through reset.
- SONG_LOOP_EN undefined: after note SONG_LEN-1 the FSM enters DONE and holds there until start_in.

## Test plan
- Reset, start_in, then req_in=001 held; mem[0]=395 → ack_out=001, valid_out=1, freq_out=395 exactly 3 cycles after the ARB sampling cycle; song_idx_out=1 afterwards.
- req_in=111 held from start; mem[0..2]=395,264,264 → acks 001,010,100 in order, 4 cycles apart, freqs 395,264,264.
- last_grant=1, req_in=101 → ack 100 first, then 001; wall 2 is never starved under continuous req_in=111.
- SONG_LEN=4, continuous requests, mem[0..3]=395,264,264,314 → fourth ack carries 314 with final_note_out=1.
  - Loop off: state_out=5 and no further acks.
  - SONG_LOOP_EN on: fifth ack carries 395.
- Assert rst_in during FETCH → mem_rd_out, ack_out, valid_out drop to 0 without waiting for a clock edge, state_out=0; the later start_in reissues note 0.
- In DONE, pulse start_in with req_in=010 → ack 010 with mem[0]; song_idx_out restarts at 0→1.

Source files
------------

// File: rtl/note_scheduler_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : note_scheduler_if
// Purpose  : Wall request/ack bus plus note-memory read port for note_scheduler.
// Revision : 1.0  initial release
// ============================================================================
interface note_scheduler_if #(
    parameter int WALL_COUNT = 3,
    parameter int ADDR_WIDTH = 5,
    parameter int FREQ_WIDTH = 16
);
    logic [WALL_COUNT-1:0] req_in;
    logic [WALL_COUNT-1:0] ack_out;
    logic [FREQ_WIDTH-1:0] freq_out;
    logic                  valid_out;
    logic                  final_note_out;
    logic [ADDR_WIDTH-1:0] mem_addr_out;
    logic                  mem_rd_out;
    logic [FREQ_WIDTH-1:0] mem_data_in;

    modport master (
        input  req_in,
        input  mem_data_in,
        output ack_out,
        output freq_out,
        output valid_out,
        output final_note_out,
        output mem_addr_out,
        output mem_rd_out
    );

    modport slave (
        output req_in,
        output mem_data_in,
        input  ack_out,
        input  freq_out,
        input  valid_out,
        input  final_note_out,
        input  mem_addr_out,
        input  mem_rd_out
    );
endinterface
`default_nettype wire

// File: rtl/note_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : note_scheduler
// Purpose  : Round-robin server of song notes to requesting walls; owns the
//            song pointer and the note memory read port. Optional feature
//            macro SONG_LOOP_EN wraps the song instead of stopping in DONE.
// Revision : 1.0  initial release
// ============================================================================
module note_scheduler #(
    parameter int WALL_COUNT = 3,
    parameter int SONG_LEN   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FREQ_WIDTH = 16
) (
    input  wire logic              pixel_clk_in,
    input  wire logic              rst_in,
    input  wire logic              start_in,
    note_scheduler_if.master       bus,
    output logic [ADDR_WIDTH-1:0]  song_idx_out,
    output logic [2:0]             state_out
);

    localparam int                    c_grant_w  = (WALL_COUNT > 1) ? $clog2(WALL_COUNT) : 1;
    localparam logic [ADDR_WIDTH-1:0] c_last_idx = ADDR_WIDTH'(SONG_LEN - 1);
    localparam logic [c_grant_w-1:0]  c_rr_init  = c_grant_w'(WALL_COUNT - 1);
    localparam logic [WALL_COUNT-1:0] c_one      = WALL_COUNT'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARB     = 3'd1,
        S_FETCH   = 3'd2,
        S_CAPTURE = 3'd3,
        S_ISSUE   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                r_state,      w_state_nxt;
    logic                  r_prev_issue, w_prev_issue_nxt;
    logic [ADDR_WIDTH-1:0] r_song_idx,   w_song_idx_nxt;
    logic [c_grant_w-1:0]  r_last_grant, w_last_grant_nxt;
    logic [c_grant_w-1:0]  r_grant_idx,  w_grant_idx_nxt;
    logic [FREQ_WIDTH-1:0] r_freq,       w_freq_nxt;
    logic [WALL_COUNT-1:0] r_ack,        w_ack_nxt;
    logic                  r_valid,      w_valid_nxt;
    logic                  r_final,      w_final_nxt;
    logic [ADDR_WIDTH-1:0] r_mem_addr,   w_mem_addr_nxt;
    logic                  r_mem_rd,     w_mem_rd_nxt;

    logic [WALL_COUNT-1:0] w_excl;
    logic [WALL_COUNT-1:0] w_mask;
    logic                  w_found;
    logic [c_grant_w-1:0]  w_winner;
    logic [c_grant_w-1:0]  w_idx;
    int                    w_pos;

    // The wall just served is excluded for one arbitration so it cannot win
    // again on a request it has not yet had the chance to drop.
    always_comb begin
        w_excl = '0;
        if (r_prev_issue) begin
            w_excl = c_one << r_last_grant;
        end
        w_mask   = bus.req_in & ~w_excl;
        w_found  = 1'b0;
        w_winner = '0;
        w_pos    = 0;
        w_idx    = '0;
        for (int k = 0; k < WALL_COUNT; k++) begin
            w_pos = int'(r_last_grant) + 1 + k;
            if (w_pos >= WALL_COUNT) begin
                w_pos = w_pos - WALL_COUNT;
            end
            w_idx = c_grant_w'(w_pos);
            if (!w_found && w_mask[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_prev_issue_nxt = (r_state == S_ISSUE);
        w_song_idx_nxt   = r_song_idx;
        w_last_grant_nxt = r_last_grant;
        w_grant_idx_nxt  = r_grant_idx;
        w_freq_nxt       = r_freq;
        w_ack_nxt        = r_ack;
        w_valid_nxt      = r_valid;
        w_final_nxt      = r_final;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_rd_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start_in) begin
                    w_song_idx_nxt = '0;
                    w_state_nxt    = S_ARB;
                end
            end
            S_ARB: begin
                if (w_found) begin
                    w_grant_idx_nxt = w_winner;
                    w_mem_addr_nxt  = r_song_idx;
                    w_mem_rd_nxt    = 1'b1;
                    w_state_nxt     = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_freq_nxt       = bus.mem_data_in;
                w_ack_nxt        = c_one << r_grant_idx;
                w_valid_nxt      = 1'b1;
                w_last_grant_nxt = r_grant_idx;
                w_final_nxt      = (r_song_idx == c_last_idx);
                w_state_nxt      = S_ISSUE;
            end
            S_ISSUE: begin
                w_ack_nxt   = '0;
                w_valid_nxt = 1'b0;
                w_final_nxt = 1'b0;
                if (r_song_idx == c_last_idx) begin
`ifdef SONG_LOOP_EN
                    w_song_idx_nxt = '0;
                    w_state_nxt    = S_ARB;
`else
                    w_state_nxt    = S_DONE;
`endif
                end else begin
                    w_song_idx_nxt = r_song_idx + 1'b1;
                    w_state_nxt    = S_ARB;
                end
            end
            S_DONE: begin
                if (start_in) begin
                    w_song_idx_nxt   = '0;
                    w_last_grant_nxt = c_rr_init;
                    w_state_nxt      = S_ARB;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= S_IDLE;
            r_prev_issue <= 1'b0;
            r_song_idx   <= '0;
            r_last_grant <= c_rr_init;
            r_grant_idx  <= '0;
            r_freq       <= '0;
            r_ack        <= '0;
            r_valid      <= 1'b0;
            r_final      <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_rd     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev_issue <= w_prev_issue_nxt;
            r_song_idx   <= w_song_idx_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_grant_idx  <= w_grant_idx_nxt;
            r_freq       <= w_freq_nxt;
            r_ack        <= w_ack_nxt;
            r_valid      <= w_valid_nxt;
            r_final      <= w_final_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_rd     <= w_mem_rd_nxt;
        end
    end

    assign bus.ack_out        = r_ack;
    assign bus.freq_out       = r_freq;
    assign bus.valid_out      = r_valid;
    assign bus.final_note_out = r_final;
    assign bus.mem_addr_out   = r_mem_addr;
    assign bus.mem_rd_out     = r_mem_rd;
    assign song_idx_out       = r_song_idx;
    assign state_out          = r_state;

endmodule
`default_nettype wire

// File: tb/tb_note_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_note_scheduler
// Purpose  : Scoreboard bench for note_scheduler with a 4-note song; honours
//            SONG_LOOP_EN the same way as the design.
// Revision : 1.0  initial release
// ============================================================================
module tb_note_scheduler;

    localparam int c_walls = 3;
    localparam int c_len   = 4;
    localparam int c_aw    = 5;
    localparam int c_fw    = 16;

    typedef struct {
        logic [c_walls-1:0] ack;
        logic [c_fw-1:0]    freq;
        logic               fin;
        int                 gap;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [c_aw-1:0] song_idx;
    logic [2:0]      state;

    exp_t            q[$];
    exp_t            e;
    int              n_checks = 0;
    int              n_errors = 0;
    int              cyc = 0;
    int              last_ack_cyc = 0;
    logic [c_fw-1:0] mem [0:31];

    note_scheduler_if #(.WALL_COUNT(c_walls), .ADDR_WIDTH(c_aw), .FREQ_WIDTH(c_fw)) bus ();

    note_scheduler #(
        .WALL_COUNT (c_walls),
        .SONG_LEN   (c_len),
        .ADDR_WIDTH (c_aw),
        .FREQ_WIDTH (c_fw)
    ) dut (
        .pixel_clk_in (clk),
        .rst_in       (rst),
        .start_in     (start),
        .bus          (bus),
        .song_idx_out (song_idx),
        .state_out    (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.mem_rd_out) bus.mem_data_in <= mem[bus.mem_addr_out];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [c_walls-1:0] a, input logic [c_fw-1:0] f,
                        input logic fin, input int gap);
        exp_t x;
        x.ack = a; x.freq = f; x.fin = fin; x.gap = gap;
        q.push_back(x);
    endtask

    task automatic wait_ack(input int max_cycles);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.valid_out && n < max_cycles);
        chk("ack_timeout", int'(bus.valid_out), 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Monitor: every acked note is popped from the scoreboard and compared.
    always begin
        @(negedge clk);
        if (!rst) begin
            if (bus.valid_out) begin
                if (q.size() == 0) begin
                    chk("unexpected_ack", int'(bus.ack_out), 0);
                end else begin
                    e = q.pop_front();
                    chk("ack_onehot", int'(bus.ack_out), int'(e.ack));
                    chk("freq", int'(bus.freq_out), int'(e.freq));
                    chk("final_note", int'(bus.final_note_out), int'(e.fin));
                    if (e.gap != 0) chk("issue_gap", cyc - last_ack_cyc, e.gap);
                end
                last_ack_cyc = cyc;
            end else begin
                chk("pulse_without_valid", int'(bus.ack_out) + int'(bus.final_note_out), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[0] = 16'd395; mem[1] = 16'd264; mem[2] = 16'd264; mem[3] = 16'd314;
        rst = 1'b1; start = 1'b0; bus.req_in = '0;

        repeat (2) @(negedge clk);
        chk("rst_state", int'(state), 0);
        chk("rst_song_idx", int'(song_idx), 0);
        chk("rst_ack", int'(bus.ack_out), 0);
        chk("rst_valid", int'(bus.valid_out), 0);
        chk("rst_freq", int'(bus.freq_out), 0);
        chk("rst_mem_rd", int'(bus.mem_rd_out), 0);
        chk("rst_mem_addr", int'(bus.mem_addr_out), 0);
        chk("rst_final", int'(bus.final_note_out), 0);
        @(posedge clk); #1 rst = 1'b0;

        // Single requester, request-to-ack latency of three cycles after ARB
        @(posedge clk); #1;
        bus.req_in = 3'b001;
        push(3'b001, 16'd395, 1'b0, 0);
        pulse_start();
        @(negedge clk);
        chk("arb_state", int'(state), 1);
        repeat (3) @(negedge clk);
        chk("latency_valid", int'(bus.valid_out), 1);
        chk("latency_ack", int'(bus.ack_out), 1);
        @(posedge clk); #1 bus.req_in = '0;
        @(negedge clk);
        chk("song_idx_after_issue", int'(song_idx), 1);

        // start outside IDLE/DONE has no effect
        @(posedge clk); #1;
        pulse_start();
        @(negedge clk);
        chk("start_ignored_state", int'(state), 1);
        chk("start_ignored_idx", int'(song_idx), 1);

        // last_grant=1 then req=101: wall 2 before wall 0, final note last
        push(3'b010, 16'd264, 1'b0, 0);
        push(3'b100, 16'd264, 1'b0, 4);
        push(3'b001, 16'd314, 1'b1, 4);
        @(posedge clk); #1 bus.req_in = 3'b010;
        wait_ack(20);
        @(posedge clk); #1 bus.req_in = 3'b101;
        wait_ack(20);
        wait_ack(20);
        @(posedge clk); #1 bus.req_in = '0;
        @(negedge clk);
`ifdef SONG_LOOP_EN
        chk("end_state_loop", int'(state), 1);
        chk("end_idx_loop", int'(song_idx), 0);
`else
        chk("end_state_done", int'(state), 5);
        chk("end_idx_done", int'(song_idx), c_len - 1);
`endif
        repeat (6) @(negedge clk);

`ifndef SONG_LOOP_EN
        // Restart from DONE with a single requester
        chk("done_hold", int'(state), 5);
        @(posedge clk); #1;
        bus.req_in = 3'b010;
        push(3'b010, 16'd395, 1'b0, 0);
        pulse_start();
        wait_ack(20);
        chk("restart_idx_issue", int'(song_idx), 0);
        @(posedge clk); #1 bus.req_in = '0;
        @(negedge clk);
        chk("restart_idx_next", int'(song_idx), 1);
`endif

        // Asynchronous reset landing mid-FETCH
        @(posedge clk); #1 bus.req_in = 3'b001;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (state != 3'd2 && n < 10);
        end
        chk("fetch_reached", int'(state), 2);
        chk("fetch_mem_rd", int'(bus.mem_rd_out), 1);
        #1 rst = 1'b1;
        #1;
        chk("async_mem_rd", int'(bus.mem_rd_out), 0);
        chk("async_ack", int'(bus.ack_out), 0);
        chk("async_valid", int'(bus.valid_out), 0);
        chk("async_state", int'(state), 0);
        chk("async_freq", int'(bus.freq_out), 0);
        chk("async_idx", int'(song_idx), 0);
        bus.req_in = '0;
        @(negedge clk); #1 rst = 1'b0;

        // All walls requesting from start: strict round-robin through the song
        @(posedge clk); #1;
        bus.req_in = 3'b111;
        push(3'b001, 16'd395, 1'b0, 0);
        push(3'b010, 16'd264, 1'b0, 4);
        push(3'b100, 16'd264, 1'b0, 4);
        push(3'b001, 16'd314, 1'b1, 4);
`ifdef SONG_LOOP_EN
        push(3'b010, 16'd395, 1'b0, 4);
`endif
        pulse_start();
        wait_ack(20);
        wait_ack(20);
        wait_ack(20);
        wait_ack(20);
`ifdef SONG_LOOP_EN
        wait_ack(20);
`endif
        @(posedge clk); #1 bus.req_in = '0;
        @(negedge clk);
`ifdef SONG_LOOP_EN
        chk("rr_end_state", int'(state), 1);
`else
        chk("rr_end_state", int'(state), 5);
`endif
        repeat (8) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
